scan_pattern_driver: RTL and testbench
======================================

// Module: scan_pattern_driver
// PURPOSE
//  Drives scan patterns into a design's scan chain and checks what comes back.
//  For each requested pattern it loads the chain, pulses one capture cycle, then
//  unloads the chain and compares the result against expected data under a mask.
//  It connects to the scan_in0/scan_en/test_mode inputs and the scan_out0 output of
//  a scan-inserted core such as switch. It is used in on-chip BIST wrappers and in
//  self-checking benches.
// PARAMETERS
//  CHAIN_LEN  32  number of flops in the scan chain (N); N >= 2
//  CNT_W       6  bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN
//  FCNT_W      8  width of the saturating fail counter
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          asynchronous, active-low reset
//  start       in   1          request one pattern; sampled only in IDLE
//  abort       in   1          synchronous abort of the current pattern
//  clr_fail    in   1          synchronous clear of fail_count
//  pattern_in  in   CHAIN_LEN  load data; latched when start is accepted
//  expect_in   in   CHAIN_LEN  expected unload data; latched with start
//  mask_in     in   CHAIN_LEN  1 = compare this bit; latched with start
//  scan_out0   in   1          serial output of the chain under test
//  scan_in0    out  1          serial input to the chain (registered)
//  scan_en     out  1          1 = shift, 0 = functional/capture (registered)
//  test_mode   out  1          1 from accepted start until DONE (registered)
//  busy        out  1          1 in any state other than IDLE
//  done        out  1          one-cycle pulse; fail and captured are valid with it
//  fail        out  1          1 if (captured ^ expect) & mask is non-zero
//  captured    out  CHAIN_LEN  unloaded response, in the same bit order as pattern_in
//  fail_count  out  FCNT_W     number of failing patterns; saturates at all-ones
// BEHAVIOUR
//  Reset (reset=0): all outputs 0, FSM in IDLE, counters 0.
//   Takes effect immediately, including in the middle of a pattern.
//  FSM states: IDLE -> SHIFT -> CAPTURE -> UNLOAD -> DONE -> IDLE.
//  IDLE:
//   - start=1 latches pattern/expect/mask, sets test_mode=1, goes to SHIFT.
//   - start in any other state is ignored; requests are not queued.
//  SHIFT (N cycles):
//   - scan_en=1.
//   - Shift cycle k (k=0..N-1) drives scan_in0 = pattern[N-1-k].
//   - After N shifts, pattern[i] sits in chain flop i (flop N-1 is nearest scan_out0).
//  CAPTURE (1 cycle): scan_en=0, scan_in0=0.
//  UNLOAD (N cycles):
//   - scan_en=1, scan_in0=0.
//   - scan_out0 is sampled at the end of unload cycle k into captured[N-1-k].
//  DONE (1 cycle):
//   - done=1, scan_en=0, test_mode=0.
//   - fail = |((captured ^ expect) & mask).
//   - fail_count increments if fail=1 (held at max, no wrap).
//   - Next state is IDLE; start is accepted again from the following cycle.
//  Latency: start accepted at edge 0 -> done high in cycle 2N+2.
//  captured and fail hold their values until the next done; cleared only by reset.
//  abort=1 in SHIFT/CAPTURE/UNLOAD:
//   - Next cycle: IDLE, scan_en=0, test_mode=0, scan_in0=0.
//   - No done pulse; fail, captured and fail_count unchanged.
//  abort in IDLE or DONE: no effect (DONE completes normally).
//  clr_fail=1 zeroes fail_count. If it coincides with a failing DONE, the result is 0.
//  Bit counter runs 0..N-1 and reloads to 0 on every state change; it never wraps mid-phase.
// TESTING
//  Bench: CHAIN_LEN=4. Behavioural 4-flop chain model; on capture each flop loads its
//   own inverted value.
//  1. Hold reset=0 while driving start=1 -> all outputs 0, busy=0.
//     Release reset -> still IDLE.
//  2. pattern=4'b1011, expect=4'b0100, mask=4'hF, start
//     -> scan_in0 sequence 1,0,1,1; scan_en low only in cycle 5;
//     -> done in cycle 10 with captured=4'b0100, fail=0.
//  3. Same pattern, expect=4'b0101, mask=4'hF -> fail=1, fail_count=1.
//     Repeat with mask=4'b1110 -> fail=0, fail_count stays 1.
//  4. Second start pulse in cycles 3 and 10 of a run -> ignored (exactly one done).
//     start in the cycle after done -> accepted.
//  5. abort in shift cycle 2 -> next cycle IDLE, scan_en=0, test_mode=0, no done,
//     captured unchanged.
//  6. reset=0 in unload cycle 1 -> outputs 0 asynchronously.
//     With FCNT_W=2, 5 failing patterns -> fail_count=3; clr_fail -> 0.

Source files
------------

// File: rtl/scan_pattern_driver.sv
// Scan pattern driver: loads a pattern into a scan chain, pulses one capture
// cycle, unloads the response and compares it against expected data under a mask.
module scan_pattern_driver #(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 6,
  parameter int FCNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 clr_fail,
  input  logic [CHAIN_LEN-1:0] pattern_in,
  input  logic [CHAIN_LEN-1:0] expect_in,
  input  logic [CHAIN_LEN-1:0] mask_in,
  input  logic                 scan_out0,
  output logic                 scan_in0,
  output logic                 scan_en,
  output logic                 test_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [CHAIN_LEN-1:0] captured,
  output logic [FCNT_W-1:0]    fail_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0]   sr_q, sr_d;
  logic [CHAIN_LEN-1:0]   exp_q, exp_d;
  logic [CHAIN_LEN-1:0]   mask_q, mask_d;
  logic [CHAIN_LEN-1:0]   captured_q, captured_d;
  logic                   fail_q, fail_d;
  logic [FCNT_W-1:0]      fail_count_q, fail_count_d;
  logic                   scan_in0_q, scan_in0_d;
  logic                   scan_en_q, scan_en_d;
  logic                   test_mode_q, test_mode_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cnt_last;
  logic                   fail_inc;

  function automatic logic masked_miscompare(input logic [CHAIN_LEN-1:0] got,
                                             input logic [CHAIN_LEN-1:0] exp,
                                             input logic [CHAIN_LEN-1:0] msk);
    return |((got ^ exp) & msk);
  endfunction

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    exp_d        = exp_q;
    mask_d       = mask_q;
    captured_d   = captured_q;
    fail_d       = fail_q;
    fail_inc     = 1'b0;
    cnt_last     = (cnt_q == CNT_LAST);

    // sr_q doubles as the load shifter (MSB drives scan_in0) and the unload collector
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          sr_d    = pattern_in;
          exp_d   = expect_in;
          mask_d  = mask_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        sr_d = {sr_q[CHAIN_LEN-2:0], 1'b0};
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_last) begin
          state_d = S_CAPTURE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        sr_d = {sr_q[CHAIN_LEN-2:0], scan_out0};
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_last) begin
          state_d    = S_DONE;
          captured_d = sr_d;
          fail_d     = masked_miscompare(sr_d, exp_q, mask_q);
          fail_inc   = fail_d;
        end else begin
          state_d = S_UNLOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_d == state_q) && ((state_q == S_SHIFT) || (state_q == S_UNLOAD))) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end

    if (clr_fail) begin
      fail_count_d = '0;
    end else if (fail_inc && (fail_count_q != '1)) begin
      fail_count_d = fail_count_q + 1'b1;
    end else begin
      fail_count_d = fail_count_q;
    end

    scan_en_d   = (state_d == S_SHIFT) || (state_d == S_UNLOAD);
    scan_in0_d  = (state_d == S_SHIFT) && sr_d[CHAIN_LEN-1];
    test_mode_d = (state_d == S_SHIFT) || (state_d == S_CAPTURE) || (state_d == S_UNLOAD);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      exp_q        <= '0;
      mask_q       <= '0;
      captured_q   <= '0;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
      scan_in0_q   <= 1'b0;
      scan_en_q    <= 1'b0;
      test_mode_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      exp_q        <= exp_d;
      mask_q       <= mask_d;
      captured_q   <= captured_d;
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
      scan_in0_q   <= scan_in0_d;
      scan_en_q    <= scan_en_d;
      test_mode_q  <= test_mode_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign scan_in0   = scan_in0_q;
  assign scan_en    = scan_en_q;
  assign test_mode  = test_mode_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign captured   = captured_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_scan_pattern_driver.sv
// Directed bench for scan_pattern_driver with a 4-flop behavioural chain whose
// capture loads each flop with its own inverted value.
module tb_scan_pattern_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       clr_fail;
  logic [3:0] pattern_in;
  logic [3:0] expect_in;
  logic [3:0] mask_in;
  logic       scan_out0;
  logic       scan_in0;
  logic       scan_en;
  logic       test_mode;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] captured;
  logic [1:0] fail_count;

  logic [3:0] chain_m = 4'b0000;
  int checks = 0;
  int errors = 0;
  int dones;

  always #5 clk = ~clk;

  scan_pattern_driver #(.CHAIN_LEN(4), .CNT_W(3), .FCNT_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .clr_fail   (clr_fail),
    .pattern_in (pattern_in),
    .expect_in  (expect_in),
    .mask_in    (mask_in),
    .scan_out0  (scan_out0),
    .scan_in0   (scan_in0),
    .scan_en    (scan_en),
    .test_mode  (test_mode),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .captured   (captured),
    .fail_count (fail_count)
  );

  // Chain under test: shift toward flop 3, capture inverts every flop
  always @(posedge clk) begin
    if (scan_en) chain_m <= {chain_m[2:0], scan_in0};
    else if (test_mode) chain_m <= ~chain_m;
  end
  assign scan_out0 = chain_m[3];

  task automatic chk(input string tag, input string name,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, name, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, "scan_in0", scan_in0, 0);
    chk(tag, "scan_en", scan_en, 0);
    chk(tag, "test_mode", test_mode, 0);
    chk(tag, "busy", busy, 0);
    chk(tag, "done", done, 0);
    chk(tag, "fail", fail, 0);
    chk(tag, "captured", captured, 0);
    chk(tag, "fail_count", fail_count, 0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the cycle after done
  task automatic run_pat(input logic [3:0] pat, input logic [3:0] exp, input logic [3:0] msk,
                         input logic exp_fail, input logic [1:0] exp_cnt, input string tag);
    logic [3:0] exp_cap;
    exp_cap = ~pat;
    pattern_in = pat;
    expect_in  = exp;
    mask_in    = msk;
    start      = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk(tag, "scan_en", scan_en, (c != 5 && c != 10));
      chk(tag, "done", done, (c == 10));
      if (c <= 4) chk(tag, "scan_in0", scan_in0, pat[4-c]);
      if (c <= 9) chk(tag, "test_mode", test_mode, 1);
    end
    chk(tag, "captured", captured, exp_cap);
    chk(tag, "fail", fail, exp_fail);
    chk(tag, "fail_count", fail_count, exp_cnt);
    chk(tag, "test_mode_done", test_mode, 0);
    @(negedge clk);
    chk(tag, "busy_after", busy, 0);
    chk(tag, "done_after", done, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; abort = 1'b0; clr_fail = 1'b0;
    pattern_in = 4'b1011; expect_in = 4'b0100; mask_in = 4'hF;

    // 1. Reset held with start asserted, then released idle
    repeat (3) @(negedge clk);
    chk_all_zero("t1_rst");
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_rel", "busy", busy, 0);
    chk("t1_rel", "test_mode", test_mode, 0);
    chk("t1_rel", "done", done, 0);

    // 2. Basic pass
    run_pat(4'b1011, 4'b0100, 4'hF, 1'b0, 2'd0, "t2");

    // 3. Fail, then masked to pass
    run_pat(4'b1011, 4'b0101, 4'hF, 1'b1, 2'd1, "t3a");
    run_pat(4'b1011, 4'b0101, 4'b1110, 1'b0, 2'd1, "t3b");

    // 4. Extra start pulses in cycles 3 and 10 are ignored
    pattern_in = 4'b1011; expect_in = 4'b0100; mask_in = 4'hF;
    start = 1'b1;
    dones = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (c == 10) chk("t4", "captured", captured, 4'b0100);
      start = (c == 3 || c == 10);
    end
    start = 1'b0;
    chk("t4", "done_count", dones, 1);
    chk("t4", "busy_c11", busy, 0);
    run_pat(4'b0110, 4'b1001, 4'hF, 1'b0, 2'd1, "t4b");

    // 5. Abort in shift cycle 2
    pattern_in = 4'b1111; expect_in = 4'b0000; mask_in = 4'hF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5", "busy", busy, 0);
    chk("t5", "scan_en", scan_en, 0);
    chk("t5", "test_mode", test_mode, 0);
    chk("t5", "scan_in0", scan_in0, 0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("t5", "done_count", dones, 0);
    chk("t5", "captured", captured, 4'b1001);
    chk("t5", "fail", fail, 0);
    chk("t5", "fail_count", fail_count, 1);

    // 6. Asynchronous reset in unload cycle 1
    pattern_in = 4'b1011; expect_in = 4'b0100; mask_in = 4'hF;
    start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("t6_pre", "scan_en", scan_en, 1);
    reset = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rel", "busy", busy, 0);

    // 6b. Fail counter saturates at 3, then clears
    run_pat(4'b1011, 4'b0101, 4'hF, 1'b1, 2'd1, "t6_f1");
    run_pat(4'b1011, 4'b0101, 4'hF, 1'b1, 2'd2, "t6_f2");
    run_pat(4'b1011, 4'b0101, 4'hF, 1'b1, 2'd3, "t6_f3");
    run_pat(4'b1011, 4'b0101, 4'hF, 1'b1, 2'd3, "t6_f4");
    run_pat(4'b1011, 4'b0101, 4'hF, 1'b1, 2'd3, "t6_f5");
    clr_fail = 1'b1;
    @(negedge clk);
    clr_fail = 1'b0;
    chk("t6_clr", "fail_count", fail_count, 0);
    chk("t6_clr", "fail_hold", fail, 1);
    chk("t6_clr", "captured_hold", captured, 4'b0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
